freq_select: RTL and testbench

//   Operator frequency entry stage for the DDS. Debounces up/down pushbuttons
//   and steps a saturating 16-bit decimal frequency value (Hz) by 1/10/100/1000.

---
 rtl/freq_select.sv | 180 ++++++++++++++++++
 tb/tb_freq_select.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_select.sv
// Operator frequency entry for the DDS: debounced up/down buttons step a
// saturating decimal value by 1/10/100/1000, with hold-to-repeat.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no button active, waiting for a single-button press
// S_WAIT | first step taken, timing the hold delay before auto-repeat
// S_RPT  | auto-repeat active, one step every REPEAT_RATE cycles
// S_LOCK | both buttons seen together, no stepping until both released
module freq_select #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned REPEAT_DLY   = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter int unsigned F_MIN        = 1,
  parameter int unsigned F_MAX        = 9999,
  parameter int unsigned F_RESET      = 1000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        btn_up_n,
  input  logic        btn_dn_n,
  input  logic [1:0]  step_sel,
  output logic [15:0] dec,
  output logic        dec_upd
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_TC   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] DLY_TC  = RP_W'(REPEAT_DLY - 1);
  localparam logic [RP_W-1:0] RATE_TC = RP_W'(REPEAT_RATE - 1);
  localparam logic [16:0]     MIN_17  = 17'(F_MIN);
  localparam logic [16:0]     MAX_17  = 17'(F_MAX);
  localparam logic [15:0]     RST_16  = 16'(F_RESET);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RPT, S_LOCK} state_t;

  // index 0 = up button, index 1 = down button; all levels active-low
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      db_q, db_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  state_t          state_q, state_d;
  logic            dir_up_q, dir_up_d;
  logic [RP_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [15:0]     dec_q, dec_d;
  logic            upd_q, upd_d;

  logic            up_p, dn_p, dir_p, other_p;
  logic            do_step, step_up;
  logic [16:0]     step_v, dec_ext, nxt;

  // Two-stage synchronizer followed by a consecutive-mismatch debounce per button
  always_comb begin
    sync1_d = {btn_dn_n, btn_up_n};
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_TC) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Shared button FSM, repeat timer and saturating step arithmetic
  always_comb begin
    up_p      = ~db_q[0];
    dn_p      = ~db_q[1];
    dir_p     = dir_up_q ? up_p : dn_p;
    other_p   = dir_up_q ? dn_p : up_p;
    state_d   = state_q;
    dir_up_d  = dir_up_q;
    rpt_cnt_d = rpt_cnt_q;
    do_step   = 1'b0;
    step_up   = dir_up_q;

    case (state_q)
      S_IDLE: begin
        rpt_cnt_d = '0;
        if (up_p && !dn_p) begin
          do_step  = 1'b1;
          step_up  = 1'b1;
          dir_up_d = 1'b1;
          state_d  = S_WAIT;
        end else if (dn_p && !up_p) begin
          do_step  = 1'b1;
          step_up  = 1'b0;
          dir_up_d = 1'b0;
          state_d  = S_WAIT;
        end else if (up_p && dn_p) begin
          state_d  = S_LOCK;
        end
      end
      S_WAIT, S_RPT: begin
        if (!dir_p) begin
          rpt_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (other_p) begin
          rpt_cnt_d = '0;
          state_d   = S_LOCK;
        end else if (rpt_cnt_q == ((state_q == S_WAIT) ? DLY_TC : RATE_TC)) begin
          do_step   = 1'b1;
          rpt_cnt_d = '0;
          state_d   = S_RPT;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RP_W'(1);
        end
      end
      S_LOCK: begin
        rpt_cnt_d = '0;
        if (!up_p && !dn_p) state_d = S_IDLE;
      end
      default: begin
        rpt_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    case (step_sel)
      2'b00:   step_v = 17'd1;
      2'b01:   step_v = 17'd10;
      2'b10:   step_v = 17'd100;
      default: step_v = 17'd1000;
    endcase

    dec_ext = {1'b0, dec_q};
    if (step_up) begin
      nxt = ((dec_ext + step_v) > MAX_17) ? MAX_17 : (dec_ext + step_v);
    end else begin
      nxt = (dec_ext < (MIN_17 + step_v)) ? MIN_17 : (dec_ext - step_v);
    end

    dec_d = dec_q;
    upd_d = 1'b0;
    if (do_step) begin
      dec_d = nxt[15:0];
      upd_d = (nxt[15:0] != dec_q);
    end
  end

  // State registers; buttons reset to released, value to its power-on setting
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      db_q        <= 2'b11;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      state_q     <= S_IDLE;
      dir_up_q    <= 1'b1;
      rpt_cnt_q   <= '0;
      dec_q       <= RST_16;
      upd_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      state_q     <= state_d;
      dir_up_q    <= dir_up_d;
      rpt_cnt_q   <= rpt_cnt_d;
      dec_q       <= dec_d;
      upd_q       <= upd_d;
    end
  end

  assign dec     = dec_q;
  assign dec_upd = upd_q;

endmodule

// File: tb/tb_freq_select.sv
// Bench for freq_select: a press-level model predicts each new value and
// queues it; a monitor pops one expected value per dec_upd pulse.
module tb_freq_select;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 5;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        btn_up_n = 1'b1;
  logic        btn_dn_n = 1'b1;
  logic [1:0]  step_sel = 2'b00;
  logic [15:0] dec;
  logic        dec_upd;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int cur = 1000;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  freq_select #(
    .DEBOUNCE_CYC(D),
    .REPEAT_DLY  (RD),
    .REPEAT_RATE (RR),
    .F_MIN       (1),
    .F_MAX       (9999),
    .F_RESET     (1000)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .btn_up_n (btn_up_n),
    .btn_dn_n (btn_dn_n),
    .step_sel (step_sel),
    .dec      (dec),
    .dec_upd  (dec_upd)
  );

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  function automatic int step_of(input int sel);
    case (sel)
      0:       return 1;
      1:       return 10;
      2:       return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic void model_step(input bit up, input int s);
    int v;
    if (up) v = (cur + s > 9999) ? 9999 : cur + s;
    else    v = (cur < 1 + s) ? 1 : cur - s;
    if (v != cur) exp_q.push_back(16'(v));
    cur = v;
  endfunction

  // A press held for len cycles steps at hold time 0, RD, RD+RR, RD+2*RR, ...
  function automatic void predict(input bit up, input int len, input int sel);
    if (len < D) return;
    for (int t = 0; t < len; t++)
      if (t == 0 || (t >= RD && (t - RD) % RR == 0)) model_step(up, step_of(sel));
  endfunction

  task automatic press(input bit up, input int len, input int sel);
    @(posedge clk); #1;
    step_sel = 2'(sel);
    predict(up, len, sel);
    if (up) btn_up_n = 1'b0;
    else    btn_dn_n = 1'b0;
    repeat (len) @(posedge clk);
    #1;
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  task automatic go_to(input int target);
    bit up;
    int sel;
    while (cur != target) begin
      up  = (cur < target);
      sel = 3;
      while (sel > 0 && (up ? (cur + step_of(sel) > target) : (cur - step_of(sel) < target)))
        sel--;
      press(up, 6, sel);
    end
  endtask

  // Monitor: every pulse must match the oldest predicted value
  always @(negedge clk) begin
    if (clr_n && dec_upd) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: dec=%0d, no step was expected", dec);
      end else begin
        chk("dec_on_pulse", int'(dec), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int p0;
    bit up;
    int len, sel;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_dec", int'(dec), 1000);
    chk("reset_upd", int'(dec_upd), 0);
    clr_n = 1'b1;
    p0 = pulse_cnt;
    repeat (20) @(posedge clk);
    chk("idle_no_pulse", pulse_cnt - p0, 0);
    chk("idle_dec", int'(dec), 1000);

    // single press of step 10, then a short glitch
    p0 = pulse_cnt;
    press(1'b1, 12, 1);
    press(1'b1, 2, 1);
    chk("single_press_pulses", pulse_cnt - p0, 1);
    chk("single_press_dec", int'(dec), 1010);

    // held press with auto-repeat
    go_to(1000);
    p0 = pulse_cnt;
    press(1'b1, 60, 0);
    chk("repeat_pulses", pulse_cnt - p0, 9);
    chk("repeat_dec", int'(dec), 1009);

    // random presses, glitches and step sizes
    for (int i = 0; i < 15; i++) begin
      up  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 45));
      sel = int'($urandom_range(0, 3));
      press(up, len, sel);
    end
    chk("random_dec", int'(dec), cur);

    // upper and lower clamps
    go_to(9995);
    p0 = pulse_cnt;
    press(1'b1, 6, 2);
    chk("clamp_hi_dec", int'(dec), 9999);
    chk("clamp_hi_pulses", pulse_cnt - p0, 1);
    press(1'b1, 6, 2);
    chk("clamp_hi_again_dec", int'(dec), 9999);
    chk("clamp_hi_again_pulses", pulse_cnt - p0, 1);
    go_to(5);
    press(1'b0, 6, 1);
    chk("clamp_lo_dec", int'(dec), 1);

    // both buttons together lock out stepping until both are released
    go_to(500);
    p0 = pulse_cnt;
    @(posedge clk); #1;
    step_sel = 2'b00;
    btn_up_n = 1'b0;
    btn_dn_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 btn_up_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn_dn_n = 1'b1;
    repeat (12) @(posedge clk);
    chk("lock_pulses", pulse_cnt - p0, 0);
    chk("lock_dec", int'(dec), 500);
    press(1'b0, 6, 0);
    chk("after_lock_dec", int'(dec), 499);

    // reset mid-repeat with the button still held through reset
    go_to(1000);
    p0 = pulse_cnt;
    @(posedge clk); #1;
    step_sel = 2'b00;
    predict(1'b1, 100, 0);
    btn_up_n = 1'b0;
    repeat (35) @(posedge clk);
    #1 clr_n = 1'b0;
    exp_q.delete();
    cur = 1000;
    #1;
    chk("pulses_before_reset", pulse_cnt - p0, 3);
    chk("async_reset_dec", int'(dec), 1000);
    chk("async_reset_upd", int'(dec_upd), 0);
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    predict(1'b1, 12, 0);
    repeat (12) @(posedge clk);
    #1 btn_up_n = 1'b1;
    repeat (15) @(posedge clk);
    chk("held_through_reset_dec", int'(dec), 1001);

    repeat (30) @(posedge clk);
    chk("outstanding_expected", exp_q.size(), 0);
    chk("final_dec", int'(dec), cur);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
